vedic_pipe_mul: RTL and testbench
=================================

// Module: vedic_pipe_mul
// PURPOSE
//  Pipelined, parametrised Vedic (Urdhva-Tiryagbhyam) multiplier: WIDTH x WIDTH -> 2*WIDTH.
//  Splits operands into halves, forms four half-width partial products, then merges them.
//  Merge: one carry-save stage, then a final carry-propagate adder.
//  Per-transaction signed/unsigned mode; valid/ready handshake on input and output.
//  Drop-in throughput multiplier for datapaths that previously used the fixed 24-bit combinational vedic tree.
// PARAMETERS
//  WIDTH   24   operand width; must be even and >= 4 (elaboration error otherwise)
// PORTS
//  clk        in   1        single clock, all state on rising edge
//  rst_n      in   1        synchronous reset, active-low
//  in_valid   in   1        operand pair presented
//  in_ready   out  1        block can accept operands this cycle
//  in_signed  in   1        1: a,b two's complement; 0: unsigned
//  a          in   WIDTH    multiplicand
//  b          in   WIDTH    multiplier
//  out_valid  out  1        p holds a valid product
//  out_ready  in   1        downstream accepts p
//  p          out  2*WIDTH  product (two's complement when captured in_signed=1)
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): all stage valids=0, out_valid=0, p=0; in_ready=1 the cycle after.
//  Pipeline, H=WIDTH/2; all stages advance together when adv = !(out_valid && !out_ready):
//   S1: register |a|,|b| (magnitudes if in_signed, else raw), neg = in_signed & (a[MSB]^b[MSB]).
//       Magnitude is WIDTH bits unsigned; |-2^(WIDTH-1)| = 2^(WIDTH-1) is exact.
//   S2: register pp0=aL*bL, pp1=aL*bH, pp2=aH*bL, pp3=aH*bH (each 2H bits), neg carried.
//   S3: compress pp0[2H-1:H], pp1, pp2 and pp3[H-1:0] with a WIDTH-bit full-adder row (carry-save).
//       Then a carry-propagate add of sum/carry plus pp3 upper half with carry-in.
//       Low H bits = pp0[H-1:0]; two's-complement negate the 2*WIDTH result if neg. Register into p.
//  Latency: exactly 3 cycles from input handshake (in_valid&in_ready) to out_valid, absent stalls.
//  Throughput: 1 product/cycle while out_ready=1.
//  Handshake: in_ready = adv (combinational from out_valid/out_ready only; no path from in_valid).
//   Input accepted only when in_valid && in_ready. Output consumed when out_valid && out_ready.
//   While out_valid && !out_ready: p, out_valid and all stage registers hold; in_ready=0.
//   Inputs a,b,in_signed may change freely when not accepted.
//  Bubbles travel through the pipe as invalid slots; they are not collapsed.
//   A stall blocks upstream even if internal stages hold bubbles.
//  Simultaneous output consume and input accept in one cycle is allowed (full rate).
//  p updates only on advance into a valid S3 slot; on a bubble advance, p holds and out_valid=0.
//  Width rules: results exact for all inputs; unsigned max (2^W-1)^2 and signed (-2^(W-1))^2 = 2^(2W-2) fit 2W bits.
//  Reset mid-operation: in-flight products discarded, no spurious out_valid after reset release.
// TESTING (WIDTH=24)
//  1 Unsigned a=0xFFFFFF,b=0xFFFFFF,out_ready=1 -> 3 cycles later out_valid=1, p=0xFFFFFE000001.
//  2 Signed a=0x800000,b=0x800000 -> p=0x400000000000; signed a=0x800000,b=0x000001 -> p=0xFFFFFF800000.
//  3 Mixed mode: back-to-back signed a=b=0xFFFFFF (p=0x000000000001) then unsigned same operands
//    (p=0xFFFFFE000001) -> consecutive cycles, in order, correct mode per product.
//  4 Back-pressure: stream 5 products, hold out_ready=0 for 4 cycles after first out_valid.
//    -> p held stable, in_ready=0, no loss or duplication; in-order release after out_ready=1.
//  5 Reset mid-stream: rst_n=0 with 3 products in flight -> next cycle out_valid=0, p=0;
//    none of the 3 ever appear.
//  6 Random: 10k random a,b,in_signed with random in_valid/out_ready -> every p matches reference product, order preserved.

Source files
------------

// File: rtl/vedic_pipe_mul.sv
// Three-stage pipelined Urdhva-Tiryagbhyam multiplier, WIDTH x WIDTH -> 2*WIDTH.
// Sign is stripped in S1, half-width partial products in S2, carry-save merge + CPA in S3.
module vedic_pipe_mul #(
  parameter int WIDTH = 24
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_signed,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   p
);

  localparam int W  = WIDTH;
  localparam int H  = WIDTH / 2;
  localparam int PW = 2 * WIDTH;
  localparam int MW = W + H;

  if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
    $error("vedic_pipe_mul: WIDTH must be even and >= 4");
  end

  localparam logic [W-1:0]  ONE_W = W'(1);
  localparam logic [PW-1:0] ONE_P = PW'(1);

  logic          adv;

  logic          v1_q, v1_d;
  logic          neg1_q, neg1_d;
  logic [W-1:0]  ma_q, ma_d;
  logic [W-1:0]  mb_q, mb_d;

  logic          v2_q, v2_d;
  logic          neg2_q, neg2_d;
  logic [W-1:0]  pp0_q, pp0_d;
  logic [W-1:0]  pp1_q, pp1_d;
  logic [W-1:0]  pp2_q, pp2_d;
  logic [W-1:0]  pp3_q, pp3_d;

  logic          ov_q, ov_d;
  logic [PW-1:0] p_q, p_d;

  logic [W-1:0]  t0, t1, t2;
  logic [W-1:0]  cs_sum, cs_cry;
  logic [MW-1:0] mid;
  logic [PW-1:0] prod;

  // The whole pipe freezes only when the output slot is full and not taken.
  assign adv      = !(ov_q && !out_ready);
  assign in_ready = adv;

  // S1: magnitudes; |-2^(W-1)| stays exact as an unsigned W-bit value
  always_comb begin
    v1_d   = in_valid;
    neg1_d = in_signed & (a[W-1] ^ b[W-1]);
    ma_d   = (in_signed && a[W-1]) ? (~a + ONE_W) : a;
    mb_d   = (in_signed && b[W-1]) ? (~b + ONE_W) : b;
  end

  // S2: four half-width partial products, zero-extended so each is exact in W bits
  always_comb begin
    v2_d   = v1_q;
    neg2_d = neg1_q;
    pp0_d  = {{H{1'b0}}, ma_q[H-1:0]} * {{H{1'b0}}, mb_q[H-1:0]};
    pp1_d  = {{H{1'b0}}, ma_q[H-1:0]} * {{H{1'b0}}, mb_q[W-1:H]};
    pp2_d  = {{H{1'b0}}, ma_q[W-1:H]} * {{H{1'b0}}, mb_q[H-1:0]};
    pp3_d  = {{H{1'b0}}, ma_q[W-1:H]} * {{H{1'b0}}, mb_q[W-1:H]};
  end

  // S3: everything here is weighted from bit H upward; pp0's low half passes straight through.
  always_comb begin
    t0     = pp1_q;
    t1     = pp2_q;
    t2     = {pp3_q[H-1:0], pp0_q[W-1:H]};
    cs_sum = t0 ^ t1 ^ t2;
    cs_cry = (t0 & t1) | (t0 & t2) | (t1 & t2);
    mid    = {{H{1'b0}}, cs_sum}
           + {{(H-1){1'b0}}, cs_cry, 1'b0}
           + {pp3_q[W-1:H], {W{1'b0}}};
    prod   = {mid, pp0_q[H-1:0]};
    p_d    = neg2_q ? (~prod + ONE_P) : prod;
    ov_d   = v2_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_q   <= 1'b0;
      neg1_q <= 1'b0;
      ma_q   <= '0;
      mb_q   <= '0;
      v2_q   <= 1'b0;
      neg2_q <= 1'b0;
      pp0_q  <= '0;
      pp1_q  <= '0;
      pp2_q  <= '0;
      pp3_q  <= '0;
      ov_q   <= 1'b0;
      p_q    <= '0;
    end else if (adv) begin
      v1_q <= v1_d;
      if (in_valid) begin
        neg1_q <= neg1_d;
        ma_q   <= ma_d;
        mb_q   <= mb_d;
      end
      v2_q   <= v2_d;
      neg2_q <= neg2_d;
      pp0_q  <= pp0_d;
      pp1_q  <= pp1_d;
      pp2_q  <= pp2_d;
      pp3_q  <= pp3_d;
      ov_q   <= ov_d;
      // a bubble reaching the output leaves the last product in place
      if (v2_q) p_q <= p_d;
    end
  end

  assign out_valid = ov_q;
  assign p         = p_q;

endmodule

// File: tb/tb_vedic_pipe_mul.sv
// Directed table plus hand sequences (latency, back-pressure, reset) and a random stream
// for the 24-bit pipelined multiplier; outputs checked in order against an expected queue.
module tb_vedic_pipe_mul;

  localparam int W = 24;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_signed = 1'b0;
  logic          out_ready = 1'b0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          in_ready;
  logic          out_valid;
  logic [2*W-1:0] p;

  vedic_pipe_mul #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_signed (in_signed),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p         (p)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          s;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [2*W-1:0] exp;
  } vec_t;

  int n_chk  = 0;
  int n_fail = 0;
  logic [2*W-1:0] expq[$];

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_p(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [2*W-1:0] model(input logic s, input logic [W-1:0] x, input logic [W-1:0] y);
    longint sx, sy, pr;
    sx = s ? longint'($signed(x)) : longint'({40'b0, x});
    sy = s ? longint'($signed(y)) : longint'({40'b0, y});
    pr = sx * sy;
    return pr[2*W-1:0];
  endfunction

  function automatic logic [W-1:0] pick();
    int unsigned r;
    r = $urandom % 8;
    case (r)
      0: return 24'h000000;
      1: return 24'hFFFFFF;
      2: return 24'h800000;
      3: return 24'h7FFFFF;
      default: return W'($urandom);
    endcase
  endfunction

  // One clock: drive inputs on the falling edge, then score the handshakes the next rising edge takes.
  task automatic step(input logic v, input logic s, input logic [W-1:0] ai, input logic [W-1:0] bi,
                      input logic ordy, input logic [2*W-1:0] exp, output logic acc);
    @(negedge clk);
    in_valid  = v;
    in_signed = s;
    a         = ai;
    b         = bi;
    out_ready = ordy;
    #1;
    check_bit("in_ready_rule", in_ready, !(out_valid && !out_ready));
    if (out_valid && out_ready) begin
      if (expq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL spurious_output: got p=%h expected no product at %0t", p, $time);
      end else begin
        check_p("product", p, expq.pop_front());
      end
    end
    acc = in_valid && in_ready;
    if (acc) expq.push_back(exp);
  endtask

  task automatic drain(input int budget);
    logic acc;
    for (int i = 0; i < budget && expq.size() > 0; i++)
      step(1'b0, 1'b0, '0, '0, 1'b1, '0, acc);
    n_chk++;
    if (expq.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d products outstanding expected 0", expq.size());
    end
  endtask

  vec_t tbl[14];

  initial begin
    logic acc;
    int   acc_cnt;
    int   cyc;
    logic v, s, r;
    logic [W-1:0] ra, rb;

    tbl[0]  = '{1'b0, 24'hFFFFFF, 24'hFFFFFF, 48'hFFFFFE000001};
    tbl[1]  = '{1'b1, 24'h800000, 24'h800000, 48'h400000000000};
    tbl[2]  = '{1'b1, 24'h800000, 24'h000001, 48'hFFFFFF800000};
    tbl[3]  = '{1'b1, 24'hFFFFFF, 24'hFFFFFF, 48'h000000000001};
    tbl[4]  = '{1'b0, 24'hFFFFFF, 24'hFFFFFF, 48'hFFFFFE000001};
    tbl[5]  = '{1'b0, 24'h000000, 24'hABCDEF, 48'h000000000000};
    tbl[6]  = '{1'b0, 24'h123456, 24'h000010, 48'h000001234560};
    tbl[7]  = '{1'b1, 24'h7FFFFF, 24'h7FFFFF, 48'h3FFFFF000001};
    tbl[8]  = '{1'b1, 24'h800000, 24'h7FFFFF, 48'hC00000800000};
    tbl[9]  = '{1'b1, 24'hFFFFFE, 24'h000003, 48'hFFFFFFFFFFFA};
    tbl[10] = '{1'b0, 24'h800000, 24'h800000, 48'h400000000000};
    tbl[11] = '{1'b0, 24'hFFFFFF, 24'h000002, 48'h000001FFFFFE};
    tbl[12] = '{1'b1, 24'h000003, 24'hFFFFFB, 48'hFFFFFFFFFFF1};
    tbl[13] = '{1'b0, 24'h001000, 24'h001000, 48'h000001000000};

    // reset state
    repeat (2) @(negedge clk);
    check_bit("reset_out_valid", out_valid, 1'b0);
    check_p("reset_p", p, '0);
    rst_n = 1'b1;
    #1;
    check_bit("reset_in_ready", in_ready, 1'b1);

    // latency: exactly three edges from handshake to out_valid
    @(negedge clk);
    in_valid = 1'b1; in_signed = 1'b0; a = 24'hFFFFFF; b = 24'hFFFFFF; out_ready = 1'b1;
    #1;
    check_bit("lat_in_ready", in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    check_bit("lat_cycle1", out_valid, 1'b0);
    @(negedge clk);
    check_bit("lat_cycle2", out_valid, 1'b0);
    @(negedge clk);
    check_bit("lat_cycle3", out_valid, 1'b1);
    check_p("lat_p", p, 48'hFFFFFE000001);
    @(negedge clk);
    check_bit("lat_no_dup", out_valid, 1'b0);

    // table, streamed at full rate (includes the signed/unsigned back-to-back pair)
    for (int i = 0; i < 14; i++) begin
      step(1'b1, tbl[i].s, tbl[i].a, tbl[i].b, 1'b1, tbl[i].exp, acc);
      check_bit("full_rate_accept", acc, 1'b1);
    end
    drain(10);

    // back-pressure: 4-cycle stall once the first of 5 products is visible
    for (int i = 0; i < 3; i++) step(1'b1, tbl[i].s, tbl[i].a, tbl[i].b, 1'b1, tbl[i].exp, acc);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, tbl[3].s, tbl[3].a, tbl[3].b, 1'b0, tbl[3].exp, acc);
      check_bit("bp_out_valid", out_valid, 1'b1);
      check_bit("bp_in_ready", in_ready, 1'b0);
      check_bit("bp_no_accept", acc, 1'b0);
      check_p("bp_p_hold", p, tbl[0].exp);
    end
    for (int k = 3; k < 5; k++) begin
      acc = 1'b0;
      for (int t = 0; t < 10 && !acc; t++) step(1'b1, tbl[k].s, tbl[k].a, tbl[k].b, 1'b1, tbl[k].exp, acc);
      check_bit("bp_resume_accept", acc, 1'b1);
    end
    drain(10);

    // reset with three products in flight
    for (int i = 5; i < 8; i++) step(1'b1, tbl[i].s, tbl[i].a, tbl[i].b, 1'b0, tbl[i].exp, acc);
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    check_bit("rst_mid_out_valid", out_valid, 1'b0);
    check_p("rst_mid_p", p, '0);
    rst_n = 1'b1; out_ready = 1'b1;
    expq.delete();
    #1;
    check_bit("rst_mid_in_ready", in_ready, 1'b1);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0, '0, '0, 1'b1, '0, acc);
      check_bit("rst_mid_no_ghost", out_valid, 1'b0);
    end
    step(1'b1, tbl[8].s, tbl[8].a, tbl[8].b, 1'b1, tbl[8].exp, acc);
    drain(10);

    // random stream with random valid and back-pressure
    acc_cnt = 0;
    cyc = 0;
    while (acc_cnt < 10000 && cyc < 60000) begin
      v  = ($urandom % 4) != 0;
      r  = ($urandom % 4) != 0;
      s  = 1'($urandom % 2);
      ra = pick();
      rb = pick();
      step(v, s, ra, rb, r, model(s, ra, rb), acc);
      if (acc) acc_cnt++;
      cyc++;
    end
    n_chk++;
    if (acc_cnt < 10000) begin
      n_fail++;
      $display("FAIL random_budget: got %0d accepted expected 10000", acc_cnt);
    end
    drain(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
